// File: rtl/psram_cr_if.sv
// Address/strobe side of the SRAM-style PSRAM bus. The data bus is a separate inout
// on the target so that its tristate resolution stays on a plain net.
interface psram_cr_if;
    logic [24:0] address;
    logic [1:0]  nbyte_en;
    logic        ncs;
    logic        noe;
    logic        nwe;

    modport master (output address, output nbyte_en, output ncs, output noe, output nwe);
    modport slave  (input  address, input  nbyte_en, input  ncs, input  noe, input  nwe);
endinterface

// File: rtl/psram_cr_target.sv
// PSRAM-side responder: word/byte array accesses plus decoding of the four-access
// configuration-register sequence (rd MAX, rd MAX, wr MAX select, CR data access).
module psram_cr_target #(
    parameter int unsigned MEM_AW    = 8,
    parameter logic [24:0] MAX_ADDR  = 25'h1FFFFFF,
    parameter logic [15:0] RCR_RESET = 16'h0010,
    parameter logic [15:0] BCR_RESET = 16'h9D1F,
    parameter logic [15:0] DIDR_VAL  = 16'h0343
) (
    input  logic        clk,
    input  logic        clr,
    psram_cr_if.slave   bus,
    inout  wire  [15:0] data,
    output logic [15:0] rcr,
    output logic [15:0] bcr,
    output logic        cr_wr,
    output logic        cr_rd,
    output logic        seq_err
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD1  = 2'd1,
        ST_RD2  = 2'd2,
        ST_SEL  = 2'd3
    } state_e;

    logic [1:0]  ncs_sync_q, noe_sync_q, nwe_sync_q;
    logic        nwe_d_q;
    logic        ncs_s, noe_s, nwe_s;
    logic [1:0]  flush_q;
    logic        armed_q, acc_q, rd_valid_q, rd_seen_q, wr_seen_q;
    logic [24:0] addr_q;
    logic [1:0]  nbyte_q;
    logic [15:0] rd_data_q, wr_data_q;
    logic [1:0]  sel_q, sel_d;
    state_e      state_q, state_d;
    logic [15:0] rcr_q, rcr_d, bcr_q, bcr_d;
    logic        cr_wr_q, cr_wr_d, cr_rd_q, cr_rd_d, seq_err_q, seq_err_d;
    logic        start_s, end_s, at_max_s, is_wr_s, is_rd_s, mem_we_s;
    logic [15:0] cr_val_s;
    logic [15:0] mem_q [0:(1 << MEM_AW) - 1];

    assign ncs_s = ncs_sync_q[1];
    assign noe_s = noe_sync_q[1];
    assign nwe_s = nwe_sync_q[1];

    // A strobe only counts once ncs has been seen high after reset, so an access
    // already in flight at reset release is skipped until ncs deasserts.
    assign start_s  = armed_q & ~acc_q & ~ncs_s;
    assign end_s    = acc_q & ncs_s;
    assign at_max_s = (addr_q == MAX_ADDR);
    assign is_wr_s  = wr_seen_q;
    assign is_rd_s  = rd_seen_q & ~wr_seen_q;

    assign data = (rd_valid_q & ~bus.ncs & ~bus.noe & bus.nwe) ? rd_data_q : 16'hzzzz;

    assign rcr     = rcr_q;
    assign bcr     = bcr_q;
    assign cr_wr   = cr_wr_q;
    assign cr_rd   = cr_rd_q;
    assign seq_err = seq_err_q;

    // CR value returned by a read in the SEL state
    always_comb begin
        cr_val_s = 16'h0000;
        case (sel_q)
            2'd0:    cr_val_s = rcr_q;
            2'd1:    cr_val_s = bcr_q;
            2'd2:    cr_val_s = DIDR_VAL;
            default: cr_val_s = 16'h0000;
        endcase
    end

    // Strobe synchronizers and post-reset arming
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ncs_sync_q <= 2'b11;
            noe_sync_q <= 2'b11;
            nwe_sync_q <= 2'b11;
            nwe_d_q    <= 1'b1;
            flush_q    <= 2'd0;
            armed_q    <= 1'b0;
        end else begin
            ncs_sync_q <= {ncs_sync_q[0], bus.ncs};
            noe_sync_q <= {noe_sync_q[0], bus.noe};
            nwe_sync_q <= {nwe_sync_q[0], bus.nwe};
            nwe_d_q    <= nwe_s;
            flush_q    <= (flush_q == 2'd3) ? 2'd3 : flush_q + 2'd1;
            armed_q    <= armed_q | ((flush_q == 2'd3) & ncs_s);
        end
    end

    // Per-access tracking: latch, read load, write capture, read/write marking
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            acc_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
            wr_seen_q  <= 1'b0;
            addr_q     <= 25'd0;
            nbyte_q    <= 2'b11;
            rd_data_q  <= 16'h0000;
            wr_data_q  <= 16'h0000;
        end else if (start_s) begin
            acc_q      <= 1'b1;
            rd_valid_q <= 1'b1;
            rd_seen_q  <= ~noe_s;
            wr_seen_q  <= 1'b0;
            addr_q     <= bus.address;
            nbyte_q    <= bus.nbyte_en;
            rd_data_q  <= (state_q == ST_SEL) ? cr_val_s : mem_q[bus.address[MEM_AW-1:0]];
        end else if (end_s) begin
            acc_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else if (acc_q) begin
            if (!nwe_s && !nwe_d_q && !wr_seen_q) begin
                wr_seen_q <= 1'b1;
                wr_data_q <= data;
            end
            if (!noe_s) begin
                rd_seen_q <= 1'b1;
            end
        end
    end

    // Access-end decode: FSM step, array/CR commit and status pulses
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        rcr_d     = rcr_q;
        bcr_d     = bcr_q;
        cr_wr_d   = 1'b0;
        cr_rd_d   = 1'b0;
        seq_err_d = 1'b0;
        mem_we_s  = 1'b0;
        if (end_s && (is_wr_s || is_rd_s)) begin
            case (state_q)
                ST_IDLE: begin
                    mem_we_s = is_wr_s;
                    if (is_rd_s && at_max_s) state_d = ST_RD1;
                    else                     state_d = ST_IDLE;
                end
                ST_RD1: begin
                    mem_we_s = is_wr_s;
                    if (is_rd_s && at_max_s) begin
                        state_d = ST_RD2;
                    end else begin
                        state_d   = ST_IDLE;
                        seq_err_d = 1'b1;
                    end
                end
                ST_RD2: begin
                    mem_we_s = is_wr_s;
                    if (at_max_s && is_wr_s) begin
                        state_d = ST_SEL;
                        sel_d   = wr_data_q[1:0];
                    end else if (at_max_s) begin
                        state_d = ST_RD2;
                    end else begin
                        state_d   = ST_IDLE;
                        seq_err_d = 1'b1;
                    end
                end
                ST_SEL: begin
                    state_d = ST_IDLE;
                    if (is_rd_s) begin
                        cr_rd_d = 1'b1;
                    end else if (nbyte_q == 2'b00) begin
                        case (sel_q)
                            2'd0: begin
                                rcr_d   = wr_data_q;
                                cr_wr_d = 1'b1;
                            end
                            2'd1: begin
                                bcr_d   = wr_data_q;
                                cr_wr_d = 1'b1;
                            end
                            default: cr_wr_d = 1'b0;
                        endcase
                    end else begin
                        cr_wr_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // FSM, CR and pulse registers
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_IDLE;
            sel_q     <= 2'd0;
            rcr_q     <= RCR_RESET;
            bcr_q     <= BCR_RESET;
            cr_wr_q   <= 1'b0;
            cr_rd_q   <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            rcr_q     <= rcr_d;
            bcr_q     <= bcr_d;
            cr_wr_q   <= cr_wr_d;
            cr_rd_q   <= cr_rd_d;
            seq_err_q <= seq_err_d;
        end
    end

    // Storage array, byte-masked writes, contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            if (!nbyte_q[0]) mem_q[addr_q[MEM_AW-1:0]][7:0]  <= wr_data_q[7:0];
            if (!nbyte_q[1]) mem_q[addr_q[MEM_AW-1:0]][15:8] <= wr_data_q[15:8];
        end
    end
endmodule

// File: tb/tb_psram_cr_target.sv
// Bench for psram_cr_target: an initiator-style driver queues expected read data and
// CR events; a negedge monitor pops and compares whenever the target presents them.
module tb_psram_cr_target;
    localparam logic [24:0] MAXA = 25'h1FFFFFF;

    typedef struct packed {
        logic [2:0]  pls;
        logic [15:0] rcr;
        logic [15:0] bcr;
    } ev_t;

    logic        clk;
    logic        clr;
    wire  [15:0] data;
    logic        tb_oe;
    logic [15:0] tb_dout;
    logic [15:0] rcr, bcr;
    logic        cr_wr, cr_rd, seq_err;
    logic        smp_req;

    int          n_vec;
    int          n_err;
    logic [15:0] exp_rd_q [$];
    ev_t         exp_ev_q [$];
    logic [15:0] mon_exp;
    ev_t         mon_ev;
    ev_t         mon_act;

    psram_cr_if bus_if ();

    assign data = tb_oe ? tb_dout : 16'hzzzz;

    psram_cr_target dut (
        .clk     (clk),
        .clr     (clr),
        .bus     (bus_if),
        .data    (data),
        .rcr     (rcr),
        .bcr     (bcr),
        .cr_wr   (cr_wr),
        .cr_rd   (cr_rd),
        .seq_err (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One 7-clock initiator access followed by 3 clocks of ncs high.
    task automatic acc(input logic [24:0] a, input logic wr, input logic [15:0] wd,
                       input logic [1:0] be, input logic [15:0] exp_rd);
        @(posedge clk); #1;
        bus_if.address  = a;
        bus_if.nbyte_en = be;
        bus_if.ncs      = 1'b0;
        if (wr) begin
            bus_if.nwe = 1'b0;
            tb_dout    = wd;
            tb_oe      = 1'b1;
        end else begin
            bus_if.noe = 1'b0;
            exp_rd_q.push_back(exp_rd);
        end
        repeat (6) @(posedge clk);
        #1 smp_req = ~wr;
        @(posedge clk); #1;
        smp_req    = 1'b0;
        bus_if.ncs = 1'b1;
        bus_if.noe = 1'b1;
        bus_if.nwe = 1'b1;
        tb_oe      = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic rd(input logic [24:0] a, input logic [15:0] e);
        acc(a, 1'b0, 16'h0000, 2'b00, e);
    endtask

    task automatic wr(input logic [24:0] a, input logic [15:0] d, input logic [1:0] be);
        acc(a, 1'b1, d, be, 16'h0000);
    endtask

    task automatic exp_ev(input logic [2:0] p, input logic [15:0] r, input logic [15:0] b);
        exp_ev_q.push_back('{pls: p, rcr: r, bcr: b});
    endtask

    // Monitor: read samples and status pulses against the scoreboard queues
    initial begin
        forever begin
            @(negedge clk);
            if (smp_req) begin
                n_vec++;
                if (exp_rd_q.size() == 0) begin
                    n_err++;
                    $display("FAIL rd_data: got %h, expected no read", data);
                end else begin
                    mon_exp = exp_rd_q.pop_front();
                    if (data !== mon_exp) begin
                        n_err++;
                        $display("FAIL rd_data: got %h, expected %h", data, mon_exp);
                    end
                end
            end
            if (clr && (cr_wr || cr_rd || seq_err)) begin
                n_vec++;
                mon_act = '{pls: {cr_wr, cr_rd, seq_err}, rcr: rcr, bcr: bcr};
                if (exp_ev_q.size() == 0) begin
                    n_err++;
                    $display("FAIL event: got pulses %b rcr %h bcr %h, expected none",
                             mon_act.pls, mon_act.rcr, mon_act.bcr);
                end else begin
                    mon_ev = exp_ev_q.pop_front();
                    if (mon_act !== mon_ev) begin
                        n_err++;
                        $display("FAIL event: got pulses %b rcr %h bcr %h, expected %b %h %h",
                                 mon_act.pls, mon_act.rcr, mon_act.bcr,
                                 mon_ev.pls, mon_ev.rcr, mon_ev.bcr);
                    end
                end
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        smp_req = 1'b0;
        tb_oe   = 1'b0;
        tb_dout = 16'h0000;
        clr     = 1'b0;
        bus_if.address  = 25'd0;
        bus_if.nbyte_en = 2'b11;
        bus_if.ncs = 1'b1;
        bus_if.noe = 1'b1;
        bus_if.nwe = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk16("rst_rcr", rcr, 16'h0010);
        chk16("rst_bcr", bcr, 16'h9D1F);
        chk16("rst_pulses", {13'd0, cr_wr, cr_rd, seq_err}, 16'h0000);
        @(negedge clk) clr = 1'b1;
        repeat (8) @(posedge clk);

        // Array byte-masked write/read
        wr(25'h05, 16'h0505, 2'b00);
        wr(25'hFF, 16'h7777, 2'b00);
        wr(25'h12, 16'hA5C3, 2'b00);
        rd(25'h12, 16'hA5C3);
        wr(25'h12, 16'h00FF, 2'b10);
        rd(25'h12, 16'hA5FF);

        // Reset in the middle of a read
        @(posedge clk); #1;
        bus_if.address  = 25'h12;
        bus_if.nbyte_en = 2'b00;
        bus_if.ncs = 1'b0;
        bus_if.noe = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk16("mid_rd_drive", data, 16'hA5FF);
        clr = 1'b0;
        #1;
        n_vec++;
        if (data === 16'hA5FF) begin
            n_err++;
            $display("FAIL rst_hiz: got %h, expected bus released", data);
        end
        chk16("mid_rst_rcr", rcr, 16'h0010);
        chk16("mid_rst_bcr", bcr, 16'h9D1F);
        repeat (2) @(posedge clk);
        @(negedge clk) clr = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        bus_if.ncs = 1'b1;
        bus_if.noe = 1'b1;
        repeat (8) @(posedge clk);
        rd(25'h12, 16'hA5FF);

        // CR write to BCR
        rd(MAXA, 16'h7777);
        rd(MAXA, 16'h7777);
        wr(MAXA, 16'h0001, 2'b00);
        exp_ev(3'b100, 16'h0010, 16'h1234);
        wr(MAXA, 16'h1234, 2'b00);
        rd(25'hFF, 16'h0001);

        // CR read of DIDR, then of the empty select
        rd(MAXA, 16'h0001);
        rd(MAXA, 16'h0001);
        wr(MAXA, 16'h0002, 2'b00);
        exp_ev(3'b010, 16'h0010, 16'h1234);
        rd(MAXA, 16'h0343);
        rd(25'hFF, 16'h0002);
        rd(MAXA, 16'h0002);
        rd(MAXA, 16'h0002);
        wr(MAXA, 16'h0003, 2'b00);
        exp_ev(3'b010, 16'h0010, 16'h1234);
        rd(MAXA, 16'h0000);

        // Aborted sequence, then a full RCR write with an extra MAX read
        rd(MAXA, 16'h0003);
        exp_ev(3'b001, 16'h0010, 16'h1234);
        rd(25'h05, 16'h0505);
        rd(MAXA, 16'h0003);
        rd(MAXA, 16'h0003);
        rd(MAXA, 16'h0003);
        wr(MAXA, 16'h0000, 2'b00);
        exp_ev(3'b100, 16'h0055, 16'h1234);
        wr(MAXA, 16'h0055, 2'b00);

        // Partial-byte CR write is dropped and leaves the array alone
        rd(MAXA, 16'h0000);
        rd(MAXA, 16'h0000);
        wr(MAXA, 16'h0000, 2'b00);
        wr(MAXA, 16'hBEEF, 2'b01);
        rd(25'h12, 16'hA5FF);
        rd(25'hFF, 16'h0000);
        chk16("rcr_kept", rcr, 16'h0055);

        // CR read of BCR
        rd(MAXA, 16'h0000);
        rd(MAXA, 16'h0000);
        wr(MAXA, 16'h0001, 2'b00);
        exp_ev(3'b010, 16'h0055, 16'h1234);
        rd(MAXA, 16'h1234);
        rd(25'hFF, 16'h0001);

        repeat (6) @(posedge clk);
        n_vec++;
        if (exp_ev_q.size() != 0) begin
            n_err++;
            $display("FAIL ev_drain: got %0d pending events, expected 0", exp_ev_q.size());
        end
        n_vec++;
        if (exp_rd_q.size() != 0) begin
            n_err++;
            $display("FAIL rd_drain: got %0d pending reads, expected 0", exp_rd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/psram_cr_target.md
# psram_cr_target

Clocked responder model of the PSRAM side of the asynchronous SRAM-style bus driven by the PSRAM CR interface initiator. It serves ordinary word/byte reads and writes from a small internal array. It also decodes the four-access configuration-register (CR) sequence: read MAX_ADDR, read MAX_ADDR, write MAX_ADDR with register select, then read or write CR data. It is the on-chip target for fabric loopback builds and for closed-loop verification of the initiator.

## Interface
- `MEM_AW`, 8: array index width; word index = `address[MEM_AW-1:0]`.
- `MAX_ADDR`, 25'h1FFFFFF: address that arms the CR sequence.
- `RCR_RESET`, 16'h0010: RCR reset value.
- `BCR_RESET`, 16'h9D1F: BCR reset value.
- `DIDR_VAL`, 16'h0343: read-only device ID.

Ports:
- `clk` in 1: single clock, shared with the initiator.
- `clr` in 1: asynchronous active-low reset.
- `address` in 25: bus address.
- `nbyte_en` in 2: active-low byte enables; [0] = data[7:0], [1] = data[15:8].
- `ncs` in 1: active-low chip select.
- `noe` in 1: active-low output enable.
- `nwe` in 1: active-low write enable.
- `data` inout 16: bidirectional bus.
- `rcr` out 16: current RCR.
- `bcr` out 16: current BCR.
- `cr_wr` out 1: one-clock pulse when a CR write commits.
- `cr_rd` out 1: one-clock pulse when a CR read completes.
- `seq_err` out 1: one-clock pulse when a partially matched CR sequence is aborted.

## Operation
- `ncs`, `noe` and `nwe` each pass through a 2-flop synchronizer (`*_s`); `*_d` is a 1-clock delay of `*_s`.
- **Access start** (`ncs_s` falls):
  - Latch `address` and `nbyte_en`.
  - Load `rd_data` from array[index], or from the selected CR if FSM = SEL.
  - Set `rd_valid`.
- **Write data capture:** at the 2nd consecutive clock with `nwe_s` low, capture `data` once into `wr_data`. Mark the access WRITE.
- **Read marking:** an access with `noe_s` low at any clock and no write capture is a READ. If both strobes are low, the access is a WRITE and nothing is driven.
- **Drive:** `data` = `rd_data` when `rd_valid & ~ncs & ~noe & nwe` on the raw pins; otherwise high-Z.
- **Access end** (`ncs_s` rises):
  - Clear `rd_valid`.
  - Commit the write to the array or CR.
  - Step the FSM.
  - If `ncs` rises with neither strobe seen, the access is ignored and the FSM is unchanged.
- **Array writes:** honour `nbyte_en` per byte. Array contents are not reset.
- **FSM states:** IDLE, RD1, RD2, SEL, each evaluated at access end.
  - IDLE: READ @MAX_ADDR → RD1.
  - RD1: READ @MAX_ADDR → RD2.
  - RD2: READ @MAX_ADDR → RD2 (stays). WRITE @MAX_ADDR → SEL; `sel` = `wr_data[1:0]`.
  - SEL: the access is a CR access and the array is untouched; go to IDLE.
    - `sel` 0 = RCR, 1 = BCR, 2 = DIDR (read-only), 3 = none (reads return 16'h0000).
    - A CR write commits only if `nbyte_en` = 2'b00; otherwise it is ignored and no `cr_wr` pulse is issued.
  - Any other access in RD1/RD2 → IDLE with a `seq_err` pulse. That access is an ordinary array access.
- **Array treatment of sequence accesses:** accesses 1–3 of the sequence are ordinary array accesses; the 3rd writes `wr_data` to array[MAX_ADDR index].

## Timing
- **Reset (async):**
  - FSM = IDLE, `rd_valid` = 0, so `data` goes high-Z immediately.
  - `rcr` = RCR_RESET, `bcr` = BCR_RESET.
  - `cr_wr`, `cr_rd`, `seq_err` = 0.
  - Synchronizers reset to 1.
- **Reset mid-access:** the access is discarded (no array or CR commit). After release, an access already in progress is not recognised until `ncs` deasserts.
- **Read latency:** `rd_data` is valid 3 clocks after the clock edge that drives `ncs` low (2 synchronizer + 1 load). The initiator must sample no earlier than 4 clocks after `ncs` falls. Its 7-clock access (sample at op 6) meets this.
- **Write data:** must be stable from 2 to 4 clocks after `nwe` falls.
- **Access end timing:** commit, FSM step and pulses occur on the clock edge where `ncs_s & ~ncs_d`, i.e. 2–3 clocks after raw `ncs` rises. `rcr`/`bcr` update in the same cycle as `cr_wr`.
- **Access spacing:** back-to-back accesses need ≥2 clocks of `ncs` high; the initiator provides 2.

## Test plan
- **Reset defaults:** assert `clr` = 0 mid-read → `data` high-Z the same cycle; `rcr` = 16'h0010, `bcr` = 16'h9D1F; FSM IDLE.
- **Array write/read:** write 16'hA5C3 @0x12, then read @0x12 → 16'hA5C3. Write 16'h00FF with `nbyte_en` = 2'b10, then read → 16'hA5FF.
- **CR write (BCR):** rd MAX, rd MAX, wr MAX 16'h0001, wr MAX 16'h1234 → one `cr_wr` pulse, `bcr` = 16'h1234; array[MAX] = 16'h0001.
- **CR read (DIDR):** full sequence with sel = 2 and final read → initiator captures 16'h0343; one `cr_rd` pulse; array unchanged.
- **Aborted sequence:** rd MAX, rd 0x05 → `seq_err` pulse, FSM IDLE. A following rd MAX, rd MAX, rd MAX, wr MAX 0, wr 16'h0055 → `rcr` = 16'h0055.
- **Ignored CR write:** final CR write with `nbyte_en` = 2'b01 → no `cr_wr`, `rcr` unchanged, FSM IDLE.
